// File: rtl/ob_mem_arbiter_if.sv
// ob_mem_arbiter_if: request/response bundle plus SRAM-side signals of the
// output-buffer arbiter.
//   req_*   : per-requester valid/ready write/read requests (index 0 or 1)
//   rsp_*   : read responses, one valid bit per requester, shared data
//   mem_*   : single-port SRAM macro controls (active low) and data
// Modports: slave = arbiter, master = requesters + SRAM side.
interface ob_mem_arbiter_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned COL    = 4,
    parameter int unsigned O_SIZE = 256
);
    localparam int unsigned AW = $clog2(O_SIZE);

    logic [1:0]                       req_valid_i;
    logic [1:0]                       req_ready_o;
    logic [1:0]                       req_we_i;
    logic [1:0][AW-1:0]               req_addr_i;
    logic [1:0][COL-1:0][WIDTH-1:0]   req_wdata_i;
    logic [1:0]                       rsp_valid_o;
    logic [COL-1:0][WIDTH-1:0]        rsp_data_o;
    logic                             mem_cenb_o;
    logic                             mem_wenb_o;
    logic [AW-1:0]                    mem_addr_o;
    logic [COL-1:0][WIDTH-1:0]        mem_data_o;
    logic [COL-1:0][WIDTH-1:0]        mem_data_i;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, mem_data_i,
        output req_ready_o, rsp_valid_o, rsp_data_o,
               mem_cenb_o, mem_wenb_o, mem_addr_o, mem_data_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, mem_data_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o,
               mem_cenb_o, mem_wenb_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/ob_mem_arbiter.sv
// ob_mem_arbiter: round-robin arbiter sharing one single-port output-buffer
// SRAM between the matrix_mult writeback path (requester 0) and the host /
// scan readout path (requester 1).
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : request handshake, read responses, SRAM controls/data
//   busy_o       : an access is in the issue stage or a read response is due
// Optional build macro OB_ARB_STATS_EN adds grant_cnt0_o, grant_cnt1_o
// (saturating accepted-request counters) and max_wait_o (longest
// valid-but-not-ready run of either requester, saturating).
// Timing: accept in cycle T, SRAM access driven in T+1, read response
// (rsp_valid_o pulse) in T+2.
module ob_mem_arbiter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned COL    = 4,
    parameter int unsigned O_SIZE = 256
) (
    input  logic               clk_i,
    input  logic               rst_i,
    ob_mem_arbiter_if.slave    bus,
    output logic               busy_o
`ifdef OB_ARB_STATS_EN
    ,
    output logic [15:0]        grant_cnt0_o,
    output logic [15:0]        grant_cnt1_o,
    output logic [7:0]         max_wait_o
`endif
);
    localparam int unsigned AW = $clog2(O_SIZE);

    typedef logic [COL-1:0][WIDTH-1:0] word_t;

    // Arbitration
    logic [1:0] grant_c;
    logic       accept_c;
    logic       gid_c;
    logic       sel_we_c;
    logic [AW-1:0] sel_addr_c;
    word_t      sel_wdata_c;

    // Pipeline state
    logic       ptr_q, ptr_d;
    logic       cenb_q, cenb_d;
    logic       wenb_q, wenb_d;
    logic [AW-1:0] addr_q, addr_d;
    word_t      data_q, data_d;
    logic       iss_rd_q, iss_rd_d;
    logic       iss_id_q, iss_id_d;
    logic [1:0] rsp_valid_q, rsp_valid_d;
    word_t      hold_q, hold_d;
    logic       busy_d;

    // Fixed-priority by pointer when both request; nothing granted in reset
    always_comb begin
        grant_c = 2'b00;
        if (!rst_i) begin
            case (bus.req_valid_i)
                2'b01:   grant_c = 2'b01;
                2'b10:   grant_c = 2'b10;
                2'b11:   grant_c = ptr_q ? 2'b10 : 2'b01;
                default: grant_c = 2'b00;
            endcase
        end
    end

    assign accept_c    = |grant_c;
    assign gid_c       = grant_c[1];
    assign sel_we_c    = bus.req_we_i[gid_c];
    assign sel_addr_c  = bus.req_addr_i[gid_c];
    assign sel_wdata_c = bus.req_wdata_i[gid_c];

    assign bus.req_ready_o = grant_c;

    // Next-state for pointer, issue stage, tag pipeline and response stage
    always_comb begin
        ptr_d       = ptr_q;
        cenb_d      = 1'b1;
        wenb_d      = 1'b1;
        addr_d      = addr_q;
        data_d      = data_q;
        iss_rd_d    = accept_c & ~sel_we_c;
        iss_id_d    = gid_c;
        rsp_valid_d = 2'b00;
        hold_d      = hold_q;
        busy_d      = accept_c | iss_rd_q;

        if (accept_c) begin
            ptr_d  = ~gid_c;
            cenb_d = 1'b0;
            wenb_d = ~sel_we_c;
            addr_d = sel_addr_c;
            if (sel_we_c) begin
                data_d = sel_wdata_c;
            end
        end

        if (iss_rd_q) begin
            rsp_valid_d = iss_id_q ? 2'b10 : 2'b01;
        end

        // Keep the last returned word visible after the pulse ends
        if (|rsp_valid_q) begin
            hold_d = bus.mem_data_i;
        end
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= 1'b0;
            cenb_q      <= 1'b1;
            wenb_q      <= 1'b1;
            addr_q      <= '0;
            data_q      <= '0;
            iss_rd_q    <= 1'b0;
            iss_id_q    <= 1'b0;
            rsp_valid_q <= 2'b00;
            hold_q      <= '0;
            busy_o      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            cenb_q      <= cenb_d;
            wenb_q      <= wenb_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            iss_rd_q    <= iss_rd_d;
            iss_id_q    <= iss_id_d;
            rsp_valid_q <= rsp_valid_d;
            hold_q      <= hold_d;
            busy_o      <= busy_d;
        end
    end

    assign bus.mem_cenb_o  = cenb_q;
    assign bus.mem_wenb_o  = wenb_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_data_o  = data_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    // SRAM output is only valid in the response cycle; forward it then, and
    // present the captured copy otherwise.
    assign bus.rsp_data_o  = (|rsp_valid_q) ? bus.mem_data_i : hold_q;

`ifdef OB_ARB_STATS_EN
    logic [15:0]     cnt0_q, cnt0_d;
    logic [15:0]     cnt1_q, cnt1_d;
    logic [1:0][7:0] wait_q, wait_d;
    logic [7:0]      max_q, max_d;

    // Saturating grant counters and per-requester wait runs
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        wait_d = '0;
        max_d  = max_q;
        if (grant_c[0] && (cnt0_q != 16'hFFFF)) begin
            cnt0_d = cnt0_q + 16'd1;
        end
        if (grant_c[1] && (cnt1_q != 16'hFFFF)) begin
            cnt1_d = cnt1_q + 16'd1;
        end
        for (int i = 0; i < 2; i++) begin
            if (bus.req_valid_i[i] && !grant_c[i]) begin
                wait_d[i] = (wait_q[i] == 8'hFF) ? 8'hFF : wait_q[i] + 8'd1;
            end
            if (wait_d[i] > max_d) begin
                max_d = wait_d[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
            wait_q <= '0;
            max_q  <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
            wait_q <= wait_d;
            max_q  <= max_d;
        end
    end

    assign grant_cnt0_o = cnt0_q;
    assign grant_cnt1_o = cnt1_q;
    assign max_wait_o   = max_q;
`endif
endmodule

// File: tb/tb_ob_mem_arbiter.sv
// tb_ob_mem_arbiter: randomized + directed bench for ob_mem_arbiter with a
// behavioural SRAM, a reference model updated at request acceptance, and
// queue-based scoreboards checked by an independent monitor.
module tb_ob_mem_arbiter;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned COL    = 4;
    localparam int unsigned O_SIZE = 256;
    localparam int unsigned AW     = 8;
    localparam int unsigned DW     = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
`ifdef OB_ARB_STATS_EN
    logic [15:0] gcnt0, gcnt1;
    logic [7:0]  maxw_o;
`endif

    always #5 clk = ~clk;

    ob_mem_arbiter_if #(.WIDTH(WIDTH), .COL(COL), .O_SIZE(O_SIZE)) bus ();

    ob_mem_arbiter #(.WIDTH(WIDTH), .COL(COL), .O_SIZE(O_SIZE)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus),
        .busy_o (busy)
`ifdef OB_ARB_STATS_EN
        ,
        .grant_cnt0_o (gcnt0),
        .grant_cnt1_o (gcnt1),
        .max_wait_o   (maxw_o)
`endif
    );

    // Behavioural single-port SRAM, active-low controls, 1-cycle read latency
    logic [DW-1:0] sram [O_SIZE];
    logic [DW-1:0] sram_q;
    always @(posedge clk) begin
        if (!bus.mem_cenb_o) begin
            if (!bus.mem_wenb_o) sram[bus.mem_addr_o] <= bus.mem_data_o;
            else                 sram_q <= sram[bus.mem_addr_o];
        end
    end
    assign bus.mem_data_i = sram_q;

    typedef struct {
        int            due;
        logic [1:0]    vld;
        logic [DW-1:0] data;
    } rsp_t;

    typedef struct {
        int            due;
        logic          cenb;
        logic          wenb;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          busy;
    } iss_t;

    rsp_t rsp_q[$];
    iss_t iss_q[$];
    rsp_t m_rsp;
    iss_t m_iss;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares SRAM-side outputs and read responses against queues
    always @(negedge clk) begin
        if (chk_en) begin
            if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
                m_iss = iss_q.pop_front();
                check("mem_cenb", 64'(bus.mem_cenb_o), 64'(m_iss.cenb));
                check("mem_wenb", 64'(bus.mem_wenb_o), 64'(m_iss.wenb));
                check("mem_addr", 64'(bus.mem_addr_o), 64'(m_iss.addr));
                check("mem_data", 64'(bus.mem_data_o), 64'(m_iss.data));
                check("busy",     64'(busy),           64'(m_iss.busy));
            end
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                m_rsp = rsp_q.pop_front();
                check("rsp_valid", 64'(bus.rsp_valid_o), 64'(m_rsp.vld));
                check("rsp_data",  64'(bus.rsp_data_o),  64'(m_rsp.data));
            end else begin
                check("rsp_idle", 64'(bus.rsp_valid_o), 64'(0));
            end
        end
    end

    // Requester stimulus state (held until accepted)
    logic [1:0]    p_v  = 2'b00;
    logic [1:0]    p_we = 2'b00;
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_wd   [2];

    // Reference model
    logic [DW-1:0] ref_mem [O_SIZE];
    bit            fav = 1'b0;      // requester favoured on contention
    logic [AW-1:0] m_addr = '0;     // address last presented to SRAM
    logic [DW-1:0] m_data = '0;     // data last presented to SRAM
    bit            prev_rd = 1'b0;  // a read was accepted last cycle
    int            gcnt [2];
    int            run  [2];
    int            maxw = 0;

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_v[i]    = 1'b1;
        p_we[i]   = we;
        p_addr[i] = a;
        p_wd[i]   = d;
    endtask

    // One clock cycle: drive, predict and check grant, update model, queue expectations
    task automatic step(input bit r, output logic [1:0] got);
        logic [1:0] exp_g;
        logic [1:0] vnow;
        bit         acc;
        int         id;
        bit         rsp_push;
        iss_t       ie;
        rsp_t       re;
        #1;
        rst = r;
        bus.req_valid_i    = p_v;
        bus.req_we_i       = p_we;
        bus.req_addr_i[0]  = p_addr[0];
        bus.req_addr_i[1]  = p_addr[1];
        bus.req_wdata_i[0] = p_wd[0];
        bus.req_wdata_i[1] = p_wd[1];
        @(negedge clk);
        vnow = p_v;
        if (r)                 exp_g = 2'b00;
        else if (vnow == 2'b11) exp_g = fav ? 2'b10 : 2'b01;
        else                   exp_g = vnow;
        got = bus.req_ready_o;
        check("req_ready", 64'(got), 64'(exp_g));
        acc      = (exp_g != 2'b00);
        id       = exp_g[1] ? 1 : 0;
        rsp_push = 1'b0;
        ie.due   = cyc + 1;
        re.due   = cyc + 2;
        re.vld   = 2'b00;
        re.data  = '0;
        for (int i = 0; i < 2; i++) begin
            if (vnow[i] && !exp_g[i]) run[i] = (run[i] < 255) ? run[i] + 1 : 255;
            else                      run[i] = 0;
            if (run[i] > maxw) maxw = run[i];
            if (exp_g[i] && gcnt[i] < 65535) gcnt[i]++;
        end
        if (r) begin
            ie.cenb = 1'b1; ie.wenb = 1'b1; ie.busy = 1'b0;
            m_addr = '0; m_data = '0; prev_rd = 1'b0; fav = 1'b0;
            for (int k = rsp_q.size() - 1; k >= 0; k--)
                if (rsp_q[k].due > cyc) rsp_q.delete(k);
            for (int i = 0; i < 2; i++) begin gcnt[i] = 0; run[i] = 0; end
            maxw = 0;
        end else if (acc) begin
            ie.cenb = 1'b0; ie.wenb = !p_we[id]; ie.busy = 1'b1;
            m_addr = p_addr[id];
            if (p_we[id]) begin
                m_data = p_wd[id];
                ref_mem[p_addr[id]] = p_wd[id];
            end else begin
                re.vld   = (id == 1) ? 2'b10 : 2'b01;
                re.data  = ref_mem[p_addr[id]];
                rsp_push = 1'b1;
            end
            prev_rd = !p_we[id];
            fav     = (id == 0);
            p_v[id] = 1'b0;
        end else begin
            ie.cenb = 1'b1; ie.wenb = 1'b1; ie.busy = prev_rd;
            prev_rd = 1'b0;
        end
        ie.addr = m_addr;
        ie.data = m_data;
        @(posedge clk);
        iss_q.push_back(ie);
        if (rsp_push) rsp_q.push_back(re);
    endtask

    task automatic idle(input int n);
        logic [1:0] g;
        repeat (n) step(1'b0, g);
    endtask

    task automatic drain();
        logic [1:0] g;
        int b = 0;
        while (p_v != 2'b00 && b < 20) begin step(1'b0, g); b++; end
        check("drain_done", 64'(p_v), 64'(0));
        idle(3);
    endtask

    task automatic rand_fill(input int pct);
        for (int i = 0; i < 2; i++) begin
            if (!p_v[i] && $urandom_range(99) < pct)
                set_req(i, 1'($urandom_range(1)),
                        ($urandom_range(3) == 0) ? AW'($urandom_range(255)) : AW'($urandom_range(7)),
                        DW'($urandom));
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] g;
        int n0, n1;
        for (int k = 0; k < int'(O_SIZE); k++) begin sram[k] = '0; ref_mem[k] = '0; end
        sram_q = '0;
        for (int i = 0; i < 2; i++) begin p_addr[i] = '0; p_wd[i] = '0; gcnt[i] = 0; run[i] = 0; end
        bus.req_valid_i = '0; bus.req_we_i = '0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;

        // Reset held with both requesters valid; first grant after release goes to 0
        set_req(0, 1'b1, 8'd1, 32'hCAFE0001);
        set_req(1, 1'b1, 8'd2, 32'hCAFE0002);
        repeat (3) step(1'b1, g);
        step(1'b0, g);
        check("first_grant", 64'(g), 64'(2'b01));
        drain();

        // Write by 0 then read-after-write by 1 on the next cycle
        set_req(0, 1'b1, 8'd5, 32'h11223344);
        step(1'b0, g);
        set_req(1, 1'b0, 8'd5, '0);
        step(1'b0, g);
        idle(3);

        // Continuous contention for 8 cycles: 4 grants each
        n0 = 0; n1 = 0;
        repeat (8) begin
            rand_fill(100);
            step(1'b0, g);
            if (g[0]) n0++;
            if (g[1]) n1++;
        end
        check("contend_cnt0", 64'(n0), 64'(4));
        check("contend_cnt1", 64'(n1), 64'(4));
        drain();

        // Preload 0..3 then back-to-back reads by requester 1
        for (int a = 0; a < 4; a++) begin
            set_req(0, 1'b1, AW'(a), DW'(32'hA0 + a));
            step(1'b0, g);
        end
        for (int a = 0; a < 4; a++) begin
            set_req(1, 1'b0, AW'(a), '0);
            step(1'b0, g);
        end
        idle(3);

        // Read accepted, reset on the next cycle: response dropped, pointer back to 0
        set_req(1, 1'b0, 8'd3, '0);
        step(1'b0, g);
        step(1'b1, g);
        idle(2);
        set_req(0, 1'b0, 8'd0, '0);
        set_req(1, 1'b0, 8'd1, '0);
        step(1'b0, g);
        check("grant_after_rst", 64'(g), 64'(2'b01));
        drain();

        // Randomized traffic with occasional drops and resets
        repeat (600) begin
            rand_fill(60);
            for (int i = 0; i < 2; i++)
                if (p_v[i] && $urandom_range(15) == 0) p_v[i] = 1'b0;
            step($urandom_range(99) == 0, g);
        end
        drain();

`ifdef OB_ARB_STATS_EN
        step(1'b1, g);
        idle(1);
        set_req(0, 1'b1, 8'd10, 32'h1);
        set_req(1, 1'b0, 8'd10, '0);
        step(1'b0, g);
        p_v[1] = 1'b0;
        set_req(0, 1'b1, 8'd11, 32'h2);
        step(1'b0, g);
        set_req(0, 1'b1, 8'd12, 32'h3);
        step(1'b0, g);
        idle(2);
        check("max_wait_min", 64'(maxw_o >= 8'd1), 64'(1));
        check("max_wait", 64'(maxw_o), 64'(maxw));
        check("grant_cnt0", 64'(gcnt0), 64'(gcnt[0]));
        check("grant_cnt1", 64'(gcnt1), 64'(gcnt[1]));
        repeat (65600) begin
            set_req(0, 1'b1, AW'($urandom_range(255)), DW'($urandom));
            step(1'b0, g);
        end
        idle(2);
        check("grant_cnt0_sat", 64'(gcnt0), 64'(16'hFFFF));
        check("grant_cnt0_model", 64'(gcnt0), 64'(gcnt[0]));
        check("grant_cnt1_model", 64'(gcnt1), 64'(gcnt[1]));
`endif

        idle(3);
        check("rsp_q_empty", 64'(rsp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
